rs_issue_arbiter: RTL and testbench

Issue-select controller for the reservation station. Each cycle it picks one ready RS entry using round-robin priority and tells the RS which entry to clear. It holds the picked entry index in an issue register and hands it to the functional unit with a valid/ready handshake. It sits between the RS entry array (ready vector in, clear one-hot out) and the FU issue port, and it handles squash on branch recovery.

---
 rtl/rs_arb_pkg.sv | 10 +
 rtl/rr_pick_oh.sv | 36 +++
 rtl/rs_issue_arbiter.sv | 80 ++++++++
 tb/tb_rs_issue_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rs_arb_pkg.sv
// rs_arb_pkg: shared types and sizing for the reservation-station issue arbiter.
// RS_SIZE may be overridden on the command line; it defaults to 16 entries.
`ifndef RS_SIZE
`define RS_SIZE 16
`endif
package rs_arb_pkg;
  localparam int RS_IDX_W = $clog2(`RS_SIZE);
  typedef enum logic {ARB_EMPTY, ARB_HOLD} arb_state_t;
  typedef logic [RS_IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/rr_pick_oh.sv
// rr_pick_oh: combinational round-robin picker, first set req bit at or after ptr (wrapping).
//   req_i     [N]     request vector
//   ptr_i     [IDX_W] highest-priority position
//   en_i              picker enable; no grant when low
//   gnt_oh_o  [N]     one-hot grant (0 when no grant)
//   gnt_idx_o [IDX_W] binary grant index
//   any_o             a grant was made
module rr_pick_oh
  import rs_arb_pkg::*;
#(
  parameter int N     = `RS_SIZE,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  // Rotating the doubled vector puts ptr at bit 0, so a plain lowest-bit
  // search yields the offset from ptr; N is a power of 2 so the add wraps.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[N-1:0];
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
  end
  assign any_o     = en_i & (|req_i);
  assign gnt_idx_o = ptr_i + off;
  assign gnt_oh_o  = any_o ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx_o) : '0;
endmodule

// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter: round-robin issue select from the RS ready vector into a valid/ready issue register.
//   clock_i, reset_n_i  clock, asynchronous active-low reset
//   ready_vec_i [N]     entries ready to issue
//   squash_i            branch-recovery flush
//   fu_ready_i          functional unit accepts the held entry
//   issue_valid_o       issue register holds an entry
//   issue_idx_o/oh_o    held entry as index / one-hot
//   rs_clear_oh_o [N]   entry granted this cycle, freed by the RS at the next edge
//   perf_issue_cnt_o, perf_stall_cnt_o  only when RS_ARB_PERF_EN is defined
module rs_issue_arbiter
  import rs_arb_pkg::*;
#(
  parameter int N     = `RS_SIZE,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic [N-1:0]     ready_vec_i,
  input  logic             squash_i,
  input  logic             fu_ready_i,
  output logic             issue_valid_o,
  output logic [IDX_W-1:0] issue_idx_o,
  output logic [N-1:0]     issue_oh_o,
`ifdef RS_ARB_PERF_EN
  output logic [31:0]      perf_issue_cnt_o,
  output logic [31:0]      perf_stall_cnt_o,
`endif
  output logic [N-1:0]     rs_clear_oh_o
);
  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, gnt_idx;
  logic [N-1:0]     oh_q, oh_d, gnt_oh;
  logic             xfer, load, any;
  assign xfer = issue_valid_o & fu_ready_i & ~squash_i;
  assign load = ~squash_i & (state_q == ARB_EMPTY | xfer);
  // Gating with reset keeps rs_clear_oh quiet while reset is held.
  rr_pick_oh #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req_i     (ready_vec_i),
    .ptr_i     (ptr_q),
    .en_i      (load & reset_n_i),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );
  assign rs_clear_oh_o = gnt_oh;
  assign issue_valid_o = state_q == ARB_HOLD;
  assign issue_idx_o   = idx_q;
  assign issue_oh_o    = oh_q;
  always_comb begin
    state_d = squash_i ? ARB_EMPTY : load ? (any ? ARB_HOLD : ARB_EMPTY) : state_q;
    idx_d   = squash_i ? '0 : load ? gnt_idx : idx_q;
    oh_d    = squash_i ? '0 : load ? gnt_oh : oh_q;
    idx_d   = (load & ~any) ? '0 : idx_d;
    ptr_d   = any ? gnt_idx + 1'b1 : ptr_q;
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ARB_EMPTY;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end
`ifdef RS_ARB_PERF_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_issue_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      perf_issue_cnt_o <= perf_issue_cnt_o + {31'd0, xfer};
      perf_stall_cnt_o <= perf_stall_cnt_o + {31'd0, issue_valid_o & ~fu_ready_i & ~squash_i};
    end
  end
`endif
endmodule

// File: tb/tb_rs_issue_arbiter.sv
// tb_rs_issue_arbiter: directed table-driven bench for rs_issue_arbiter (N=16).
module tb_rs_issue_arbiter;
  logic        clk = 0, rst_n = 0, squash = 0, fu_ready = 0;
  logic [15:0] ready_vec = '0, issue_oh, clear_oh;
  logic        issue_valid;
  logic [3:0]  issue_idx;
`ifdef RS_ARB_PERF_EN
  logic [31:0] perf_issue, perf_stall;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rs_issue_arbiter #(.N(16)) dut (
    .clock_i       (clk),
    .reset_n_i     (rst_n),
    .ready_vec_i   (ready_vec),
    .squash_i      (squash),
    .fu_ready_i    (fu_ready),
    .issue_valid_o (issue_valid),
    .issue_idx_o   (issue_idx),
    .issue_oh_o    (issue_oh),
`ifdef RS_ARB_PERF_EN
    .perf_issue_cnt_o (perf_issue),
    .perf_stall_cnt_o (perf_stall),
`endif
    .rs_clear_oh_o (clear_oh)
  );
  typedef struct {
    logic        rst_n;
    logic [15:0] rdy;
    logic        sq, fr;
    logic [15:0] clr;
    logic        val;
    logic [3:0]  idx;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic r, input logic [15:0] rdy, input logic sq, input logic fr,
                     input logic [15:0] clr, input logic val, input logic [3:0] idx);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.sq = sq; v.fr = fr; v.clr = clr; v.val = val; v.idx = idx;
    vq.push_back(v);
  endtask
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask
  initial begin
    logic [15:0] exp_oh;
    int xfers = 0, stalls = 0;
    //  rst  ready    sq fr  clear    val idx
    add(0, 16'hFFFF, 0, 1, 16'h0000, 0, 0);
    add(0, 16'hFFFF, 0, 1, 16'h0000, 0, 0);
    add(1, 16'h0005, 0, 1, 16'h0001, 0, 0);
    add(1, 16'h0004, 0, 1, 16'h0004, 1, 0);
    add(1, 16'h0000, 0, 1, 16'h0000, 1, 2);
    add(1, 16'h0000, 0, 1, 16'h0000, 0, 0);
    add(1, 16'h000B, 0, 1, 16'h0008, 0, 0);
    add(1, 16'h0003, 0, 0, 16'h0000, 1, 3);
    add(1, 16'h0003, 0, 1, 16'h0001, 1, 3);
    add(1, 16'h0002, 0, 1, 16'h0002, 1, 0);
    add(1, 16'h0000, 0, 1, 16'h0000, 1, 1);
    add(1, 16'h2000, 0, 1, 16'h2000, 0, 0);
    add(1, 16'h2001, 0, 0, 16'h0000, 1, 13);
    add(1, 16'h2001, 0, 1, 16'h0001, 1, 13);
    add(1, 16'h2000, 0, 1, 16'h2000, 1, 0);
    add(1, 16'h0000, 0, 1, 16'h0000, 1, 13);
    add(1, 16'h0020, 0, 1, 16'h0020, 0, 0);
    add(1, 16'h0300, 0, 0, 16'h0000, 1, 5);
    add(1, 16'h0300, 0, 0, 16'h0000, 1, 5);
    add(1, 16'h0300, 0, 0, 16'h0000, 1, 5);
    add(1, 16'h0300, 0, 1, 16'h0100, 1, 5);
    add(1, 16'h0200, 0, 1, 16'h0200, 1, 8);
    add(1, 16'h0000, 0, 1, 16'h0000, 1, 9);
    add(1, 16'h0080, 0, 1, 16'h0080, 0, 0);
    add(1, 16'h0010, 1, 1, 16'h0000, 1, 7);
    add(1, 16'h0010, 0, 1, 16'h0010, 0, 0);
    add(1, 16'h0000, 1, 0, 16'h0000, 1, 4);
    add(1, 16'h0000, 0, 0, 16'h0000, 0, 0);
    add(1, 16'h0020, 1, 1, 16'h0000, 0, 0);
    add(1, 16'h0020, 0, 1, 16'h0020, 0, 0);
    add(1, 16'h0000, 0, 1, 16'h0000, 1, 5);
    foreach (vq[r]) begin
      @(negedge clk);
      rst_n = vq[r].rst_n; ready_vec = vq[r].rdy; squash = vq[r].sq; fu_ready = vq[r].fr;
      #1;
      exp_oh = vq[r].val ? (16'h1 << vq[r].idx) : 16'h0;
      chk("clear_oh", r, 32'(clear_oh), 32'(vq[r].clr));
      chk("valid", r, 32'(issue_valid), 32'(vq[r].val));
      chk("idx", r, 32'(issue_idx), 32'(vq[r].idx));
      chk("issue_oh", r, 32'(issue_oh), 32'(exp_oh));
      if (!vq[r].rst_n) begin
        xfers = 0; stalls = 0;
      end else begin
        xfers  += int'(vq[r].val & vq[r].fr & ~vq[r].sq);
        stalls += int'(vq[r].val & ~vq[r].fr & ~vq[r].sq);
      end
    end
    @(negedge clk);
    ready_vec = '0; squash = 0; fu_ready = 0;
`ifdef RS_ARB_PERF_EN
    #1;
    chk("perf_issue", 99, perf_issue, 32'(xfers));
    chk("perf_stall", 99, perf_stall, 32'(stalls));
`endif
    @(negedge clk);
    ready_vec = 16'h0020;
    #1 chk("ar_clear", 100, 32'(clear_oh), 32'h0020);
    @(negedge clk);
    ready_vec = 16'hFFFF;
    #1 chk("ar_valid", 101, 32'(issue_valid), 1);
    chk("ar_idx", 101, 32'(issue_idx), 5);
    #1 rst_n = 0;
    #1;
    chk("async_valid", 102, 32'(issue_valid), 0);
    chk("async_idx", 102, 32'(issue_idx), 0);
    chk("async_oh", 102, 32'(issue_oh), 0);
    chk("async_clear", 102, 32'(clear_oh), 0);
`ifdef RS_ARB_PERF_EN
    chk("async_perf", 102, perf_issue, 0);
`endif
    @(negedge clk);
    rst_n = 1; ready_vec = 16'h0003;
    #1 chk("post_reset_clear", 103, 32'(clear_oh), 32'h0001);
    @(negedge clk);
    ready_vec = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
